// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel Avalon-MM PWM block:
// register offsets within a channel and CONTROL register bit layout.
package pwm_pkg;

  typedef enum logic [1:0] {
    REG_COMPARE = 2'd0,
    REG_PERIOD  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_COUNT   = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_INV_BIT    = 1;
  localparam int CTRL_WRAP_BIT   = 2;
  localparam int CTRL_IRQ_EN_BIT = 3;

  // Field order mirrors the bit positions above (MSB first).
  typedef struct packed {
    logic irq_en;
    logic wrap;
    logic inv;
    logic en;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active COMPARE and PERIOD, the counter, the sticky
// WRAP flag and the registered (optionally inverted) output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_cmp_i,
  input  logic              wr_per_i,
  input  logic              wr_ctrl_i,
  input  logic [CNT_W-1:0]  wdata_i,
  input  logic [CTRL_W-1:0] ctrl_wdata_i,
  output logic [CNT_W-1:0]  cmp_o,
  output logic [CNT_W-1:0]  per_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              pwm_o,
  output logic              irq_o
);

  logic [CNT_W-1:0] sh_cmp_q, sh_cmp_d;
  logic [CNT_W-1:0] sh_per_q, sh_per_d;
  logic [CNT_W-1:0] act_cmp_q, act_cmp_d;
  logic [CNT_W-1:0] act_per_q, act_per_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             pwm_q, pwm_d;
  logic             wrap_evt;
  logic             raw;

  assign wrap_evt = ctrl_q.en && (cnt_q == act_per_q);
  assign raw      = ctrl_q.en && (cnt_q < act_cmp_q);

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    sh_cmp_d  = sh_cmp_q;
    sh_per_d  = sh_per_q;
    act_cmp_d = act_cmp_q;
    act_per_d = act_per_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    pwm_d     = raw ^ ctrl_q.inv;

    if (wr_cmp_i) sh_cmp_d = wdata_i;
    if (wr_per_i) sh_per_d = wdata_i;

    // Reload uses the shadow held before this cycle's write, so a write landing
    // on the wrap cycle takes effect one period later.
    if (!ctrl_q.en || wrap_evt) begin
      act_cmp_d = sh_cmp_q;
      act_per_d = sh_per_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (wr_ctrl_i) begin
      ctrl_d.en     = ctrl_wdata_i[CTRL_EN_BIT];
      ctrl_d.inv    = ctrl_wdata_i[CTRL_INV_BIT];
      ctrl_d.irq_en = ctrl_wdata_i[CTRL_IRQ_EN_BIT];
      if (ctrl_wdata_i[CTRL_WRAP_BIT]) ctrl_d.wrap = 1'b0;
    end
    // Hardware set has priority over a simultaneous software clear.
    if (wrap_evt) ctrl_d.wrap = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only, and every one of
  // them (including the shadow/active datapath) has an async reset value,
  // because software expects defined register contents straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cmp_q  <= '0;
      sh_per_q  <= '1;
      act_cmp_q <= '0;
      act_per_q <= '1;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      sh_cmp_q  <= sh_cmp_d;
      sh_per_q  <= sh_per_d;
      act_cmp_q <= act_cmp_d;
      act_per_q <= act_per_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      pwm_q     <= pwm_d;
    end
  end

  assign cmp_o  = sh_cmp_q;
  assign per_o  = sh_per_q;
  assign cnt_o  = cnt_q;
  assign ctrl_o = ctrl_q;
  assign pwm_o  = pwm_q;
  assign irq_o  = ctrl_q.wrap && ctrl_q.irq_en;

endmodule

// File: rtl/avalon_mm_pwm_multi.sv
// Multi-channel PWM with an Avalon-MM slave: address decode, registered read
// mux and the interrupt OR; per-channel logic lives in pwm_channel.
module avalon_mm_pwm_multi
  import pwm_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W = CH_W + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic [31:0]       readdata,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  logic [CH_W-1:0]   ch_sel;
  reg_sel_e          reg_sel;
  logic [NUM_CH-1:0] wr_cmp, wr_per, wr_ctrl, ch_irq;
  logic [31:0]       rd_word;
  logic [31:0]       readdata_q;
  logic              unused_wdata;

  logic [CNT_W-1:0]  ch_cmp  [NUM_CH];
  logic [CNT_W-1:0]  ch_per  [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt  [NUM_CH];
  logic [CTRL_W-1:0] ch_ctrl [NUM_CH];

  assign ch_sel  = address[ADDR_W-1:2];
  assign reg_sel = reg_sel_e'(address[1:0]);

  // Upper write-data bits beyond the counter width are architecturally ignored.
  assign unused_wdata = ^writedata;

  // Channel slots without a channel never match, so writes there are dropped.
  always_comb begin
    wr_cmp  = '0;
    wr_per  = '0;
    wr_ctrl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (write && (ch_sel == CH_W'(i))) begin
        wr_cmp[i]  = (reg_sel == REG_COMPARE);
        wr_per[i]  = (reg_sel == REG_PERIOD);
        wr_ctrl[i] = (reg_sel == REG_CONTROL);
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_COMPARE: rd_word = 32'(ch_cmp[i]);
          REG_PERIOD:  rd_word = 32'(ch_per[i]);
          REG_CONTROL: rd_word = 32'(ch_ctrl[i]);
          REG_COUNT:   rd_word = 32'(ch_cnt[i]);
          default:     rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (read) begin
      readdata_q <= rd_word;
    end
  end

  assign readdata = readdata_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (reset_n),
      .wr_cmp_i     (wr_cmp[g]),
      .wr_per_i     (wr_per[g]),
      .wr_ctrl_i    (wr_ctrl[g]),
      .wdata_i      (writedata[CNT_W-1:0]),
      .ctrl_wdata_i (writedata[CTRL_W-1:0]),
      .cmp_o        (ch_cmp[g]),
      .per_o        (ch_per[g]),
      .cnt_o        (ch_cnt[g]),
      .ctrl_o       (ch_ctrl[g]),
      .pwm_o        (pwm_out[g]),
      .irq_o        (ch_irq[g])
    );
  end

  assign irq = |ch_irq;

endmodule

// File: tb/tb_avalon_mm_pwm_multi.sv
// Self-checking bench for avalon_mm_pwm_multi: directed scenarios plus random
// register traffic, compared every cycle against a timestamp-based model.
module tb_avalon_mm_pwm_multi;
  import pwm_pkg::*;

  localparam int     NUM_CH = 3;
  localparam int     CNT_W  = 16;
  localparam int     CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int     ADDR_W = CH_W + 2;
  localparam int     NSLOT  = 1 << CH_W;
  localparam longint MASK   = (longint'(1) << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic              irq;

  avalon_mm_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .readdata  (readdata),
    .write     (write),
    .writedata (writedata),
    .pwm_out   (pwm_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a running channel's count is the number of clocks since
  // its current period began; periods restart on wrap or while disabled.
  longint now = 0;
  longint m_scmp [NUM_CH], m_sper [NUM_CH], m_acmp [NUM_CH], m_aper [NUM_CH];
  longint m_start [NUM_CH];
  bit     m_en [NUM_CH], m_inv [NUM_CH], m_wrap [NUM_CH], m_irqen [NUM_CH];
  bit     m_pwm [NUM_CH];
  longint m_rd = 0;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_scmp[i] = 0; m_sper[i] = MASK; m_acmp[i] = 0; m_aper[i] = MASK;
      m_start[i] = now; m_en[i] = 0; m_inv[i] = 0; m_wrap[i] = 0;
      m_irqen[i] = 0; m_pwm[i] = 0;
    end
    m_rd = 0;
  endfunction

  function automatic longint m_count(int i);
    return m_en[i] ? (now - m_start[i]) : 0;
  endfunction

  function automatic longint m_reg(int ch, int rg);
    case (rg)
      0:       return m_scmp[ch];
      1:       return m_sper[ch];
      2:       return longint'({m_irqen[ch], m_wrap[ch], m_inv[ch], m_en[ch]});
      default: return m_count(ch);
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] m_pwm_vec();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_pwm[i];
    return v;
  endfunction

  function automatic logic m_irq();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) r |= (m_wrap[i] && m_irqen[i]);
    return r;
  endfunction

  function automatic void model_step();
    int     ch, rg;
    longint wd, c;
    bit     at_end;
    ch = int'(address) >> 2;
    rg = int'(address) & 3;
    wd = longint'(writedata) & MASK;
    if (read) m_rd = (ch < NUM_CH) ? m_reg(ch, rg) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c      = m_count(i);
      at_end = m_en[i] && (c == m_aper[i]);
      m_pwm[i] = (m_en[i] && (c < m_acmp[i])) ^ m_inv[i];
      if (!m_en[i] || at_end) begin
        m_acmp[i]  = m_scmp[i];
        m_aper[i]  = m_sper[i];
        m_start[i] = now + 1;
      end
      if (write && ch == i) begin
        case (rg)
          0: m_scmp[i] = wd;
          1: m_sper[i] = wd;
          2: begin
            m_en[i]    = writedata[0];
            m_inv[i]   = writedata[1];
            m_irqen[i] = writedata[3];
            if (writedata[2]) m_wrap[i] = 0;
          end
          default: ;
        endcase
      end
      if (at_end) m_wrap[i] = 1;
    end
    now++;
  endfunction

  // One clock: model advances with the DUT, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pwm_out", 64'(pwm_out), 64'(m_pwm_vec()));
    check("irq", 64'(irq), 64'(m_irq()));
    check("readdata", 64'(readdata), 64'(m_rd));
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(int ch, int rg, logic [31:0] d);
    address = ADDR_W'(ch * 4 + rg); writedata = d; write = 1'b1;
    tick();
  endtask

  task automatic rd(int ch, int rg);
    address = ADDR_W'(ch * 4 + rg); read = 1'b1;
    tick();
  endtask

  task automatic rd_chk(string tag, int ch, int rg, logic [31:0] exp);
    rd(ch, rg);
    check(tag, 64'(readdata), 64'(exp));
  endtask

  task automatic wait_wrap(int ch);
    int n;
    n = 0;
    do begin tick(); n++; end while (m_count(ch) != 0 && n < 40);
    if (n >= 40) check("wrap_bound", 64'(n), 64'(0));
  endtask

  task automatic count_high(int ch, int n, output int highs);
    highs = 0;
    repeat (n) begin tick(); highs += int'(pwm_out[ch]); end
  endtask

  initial begin
    int highs, irq_cnt, v0;
    bit seen;

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pwm", 64'(pwm_out), 64'(0));
    check("reset_irq", 64'(irq), 64'(0));
    check("reset_rdata", 64'(readdata), 64'(0));
    reset_n = 1'b1;
    rd_chk("rst_compare", 0, REG_COMPARE, 32'h0);
    rd_chk("rst_period", 0, REG_PERIOD, 32'(MASK));
    rd_chk("rst_control", 0, REG_CONTROL, 32'h0);
    rd_chk("rst_count", 0, REG_COUNT, 32'h0);

    // Basic waveform: PERIOD 9, COMPARE 3.
    wr(0, REG_PERIOD, 9);
    wr(0, REG_COMPARE, 3);
    wr(0, REG_CONTROL, 32'h1);
    repeat (10) tick();
    count_high(0, 20, highs);
    check("duty_3_of_10", 64'(highs), 64'(6));

    // Mid-period COMPARE write only takes effect after the wrap.
    for (int n = 0; n < 20 && m_count(0) != 4; n++) tick();
    wr(0, REG_COMPARE, 7);
    highs = int'(pwm_out[0]);
    for (int n = 0; n < 20 && m_count(0) != 0; n++) begin tick(); highs += int'(pwm_out[0]); end
    check("mid_write_old_duty", 64'(highs), 64'(0));
    count_high(0, 10, highs);
    check("duty_7_of_10", 64'(highs), 64'(7));

    // Write landing on the wrap cycle applies one period later.
    for (int n = 0; n < 20 && m_count(0) != 9; n++) tick();
    wr(0, REG_COMPARE, 2);
    count_high(0, 10, highs);
    check("wrap_write_old", 64'(highs), 64'(7));
    count_high(0, 10, highs);
    check("wrap_write_new", 64'(highs), 64'(2));

    // Boundary compares and inversion.
    wr(0, REG_COMPARE, 0);
    wait_wrap(0);
    count_high(0, 10, highs);
    check("cmp0_low", 64'(highs), 64'(0));
    wr(0, REG_COMPARE, 12);
    wait_wrap(0);
    count_high(0, 10, highs);
    check("cmp_gt_per_high", 64'(highs), 64'(10));
    wr(0, REG_CONTROL, 32'h3);
    tick();
    count_high(0, 10, highs);
    check("inv_high_low", 64'(highs), 64'(0));
    wr(0, REG_COMPARE, 0);
    wait_wrap(0);
    count_high(0, 10, highs);
    check("inv_low_high", 64'(highs), 64'(10));
    wr(0, REG_COMPARE, 3);
    wr(0, REG_CONTROL, 32'h1);

    // Interrupt on channel 2.
    wr(2, REG_PERIOD, 4);
    wr(2, REG_COMPARE, 2);
    wr(2, REG_CONTROL, 32'h9);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin tick(); seen = irq; end
    check("irq_rise_seen", 64'(seen), 64'(1));
    wr(2, REG_CONTROL, 32'hD);
    check("irq_cleared", 64'(irq), 64'(0));
    wr(2, REG_CONTROL, 32'h8);
    irq_cnt = 0;
    repeat (20) begin tick(); irq_cnt += int'(irq); end
    check("irq_quiet_disabled", 64'(irq_cnt), 64'(0));

    // Unpopulated channel slot and live COUNT reads.
    rd_chk("ch3_count", 3, REG_COUNT, 32'h0);
    wr(3, REG_COMPARE, 5);
    rd_chk("ch3_compare", 3, REG_COMPARE, 32'h0);
    wait_wrap(0);
    v0 = int'(m_count(0));
    for (int k = 0; k < 12; k++) begin
      rd(0, REG_COUNT);
      check("count_advance", 64'(readdata), 64'((v0 + k) % 10));
    end

    // Random register traffic.
    for (int it = 0; it < 400; it++) begin
      int op, ch, rg;
      op = $urandom_range(0, 3);
      ch = $urandom_range(0, NSLOT - 1);
      rg = $urandom_range(0, 3);
      case (op)
        0: tick();
        1: wr(ch, rg, (rg < 2) ? 32'($urandom_range(0, 12)) : $urandom);
        2: rd(ch, rg);
        default: wr(ch, REG_CONTROL, $urandom);
      endcase
    end

    // Asynchronous reset in the middle of a period.
    wr(0, REG_CONTROL, 32'h0);
    wr(2, REG_CONTROL, 32'h0);
    wr(0, REG_PERIOD, 9);
    wr(0, REG_COMPARE, 12);
    wr(2, REG_PERIOD, 4);
    wr(2, REG_COMPARE, 2);
    wr(0, REG_CONTROL, 32'h1);
    wr(2, REG_CONTROL, 32'h9);
    repeat (8) tick();
    rd(0, REG_PERIOD);
    check("pre_reset_pwm0", 64'(pwm_out[0]), 64'(1));
    check("pre_reset_irq", 64'(irq), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pwm", 64'(pwm_out), 64'(0));
    check("async_rst_irq", 64'(irq), 64'(0));
    check("async_rst_rdata", 64'(readdata), 64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int ch = 0; ch < NSLOT; ch++) begin
      rd_chk("post_rst_compare", ch, REG_COMPARE, 32'h0);
      rd_chk("post_rst_period", ch, REG_PERIOD, (ch < NUM_CH) ? 32'(MASK) : 32'h0);
      rd_chk("post_rst_control", ch, REG_CONTROL, 32'h0);
      rd_chk("post_rst_count", ch, REG_COUNT, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_mm_pwm_multi.md
AVALON_MM_PWM_MULTI -- requirements
Module: avalon_mm_pwm_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the PWM channel count (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the counter, period and compare width (legal range 2..32).
REQ-003 The block SHALL have localparam ADDR_W = $clog2(NUM_CH)+2, the word address width; for NUM_CH=1 the channel field is 1 bit.
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge on clk.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port address, input, ADDR_W bits: word address; bits [ADDR_W-1:2] select the channel and bits [1:0] select the register.
REQ-007 Port read, input, 1 bit: Avalon-MM read strobe.
REQ-008 Port readdata, output, 32 bits: read data, registered.
REQ-009 Port write, input, 1 bit: Avalon-MM write strobe.
REQ-010 Port writedata, input, 32 bits: write data; bits above CNT_W are ignored for COMPARE and PERIOD.
REQ-011 Port pwm_out, output, NUM_CH bits: one PWM waveform per channel.
REQ-012 Port irq, output, 1 bit: level interrupt.

Function
REQ-013 The per-channel register map SHALL be:
- reg 0 COMPARE: shadow, R/W.
- reg 1 PERIOD: shadow, R/W.
- reg 2 CONTROL: bit0 EN, bit1 INV, bit2 WRAP (sticky; write 1 clears), bit3 IRQ_EN; other bits read 0.
- reg 3 COUNT: read-only live counter; writes ignored.
REQ-014 Reads SHALL have fixed 1-cycle latency: readdata is valid on the cycle after read is sampled, zero-extended to 32 bits, and holds its value otherwise.
REQ-015 Accesses to channel index >= NUM_CH SHALL read 0, and writes to them SHALL have no effect.
REQ-016 Writes SHALL update only the shadow COMPARE/PERIOD registers.
REQ-017 Each channel SHALL hold active COMPARE/PERIOD copies used by the counter.
REQ-018 With EN=1, the counter SHALL count 0..active PERIOD and then wrap to 0, giving a period of PERIOD+1 clocks.
REQ-019 On the wrap cycle (counter == active PERIOD), active values SHALL load from shadow and WRAP SHALL set.
REQ-020 If a shadow write and a wrap occur in the same cycle on the same channel, active SHALL load the pre-write shadow; the new value takes effect at the next wrap.
REQ-021 If a CONTROL write with bit2=1 coincides with a wrap on the same channel, WRAP SHALL end set (set wins).
REQ-022 With EN=0, the counter SHALL hold 0, active values SHALL track shadow every cycle, and the raw output SHALL be 0.
REQ-023 A 0->1 transition of EN SHALL start counting from 0 with the current shadow values.
REQ-024 The raw output SHALL be (counter < active COMPARE) AND EN.
REQ-025 COMPARE=0 SHALL give constant low; COMPARE > PERIOD SHALL give constant high.
REQ-026 pwm_out[i] SHALL equal raw XOR INV, registered, i.e. 1 clock after the counter state.
REQ-027 irq SHALL be the OR over all channels of (WRAP AND IRQ_EN).
REQ-028 The counter SHALL use unsigned CNT_W-bit arithmetic with no overflow beyond PERIOD; PERIOD=all-ones SHALL wrap naturally.

Reset
REQ-029 While reset_n=0, all state SHALL clear asynchronously:
- shadow and active PERIOD = all-ones; COMPARE = 0; CONTROL = 0; counter = 0.
- readdata = 0; pwm_out = 0; irq = 0.
REQ-030 After reset_n deasserts, the block SHALL be idle (all channels disabled) until software sets EN.
REQ-031 Reset asserted mid-period SHALL abort the waveform immediately.

Structure
REQ-032 Package pwm_pkg SHALL hold the register offsets (COMPARE/PERIOD/CONTROL/COUNT) and the CONTROL bit positions.
REQ-033 A sub-module pwm_channel (parameter CNT_W) SHALL hold shadow/active registers, counter, WRAP and the output flop, and SHALL be instantiated NUM_CH times via generate.
REQ-034 The top level SHALL hold address decode, the read mux and the irq OR.

Verification
REQ-035 The bench SHALL cover: ch0 PERIOD=9, COMPARE=3, EN=1 -> pwm_out[0] high 3 clocks, low 7, repeating every 10.
REQ-036 The bench SHALL cover: write COMPARE=7 mid-period -> duty unchanged until the wrap, then high 7 of 10; same-cycle write+wrap applies one period later.
REQ-037 The bench SHALL cover: COMPARE=0 -> constant 0; COMPARE=12 with PERIOD=9 -> constant 1; INV=1 -> both inverted.
REQ-038 The bench SHALL cover: IRQ_EN=1 on ch2 -> irq rises 1 cycle after the ch2 wrap; write CONTROL bit2=1 -> irq falls; EN=0 -> no further irq.
REQ-039 The bench SHALL cover: NUM_CH=3, read ch3 COUNT -> 0; read COUNT of a running channel -> value advancing by 1 per clock with 1-cycle latency.
REQ-040 The bench SHALL cover: assert reset_n low mid-period -> pwm_out/irq/readdata 0 immediately; all registers read back at reset values afterwards.
